// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle for the BCD-to-binary converter.
// The master side supplies digits and accepts results. The slave side is the converter.
interface bcd_to_bin_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] bcd_h;
    logic [3:0] bcd_t;
    logic [3:0] bcd_o;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] bin_out;
    logic       ovf;
    logic       err;

    modport master (
        output in_valid, bcd_h, bcd_t, bcd_o, out_ready,
        input  in_ready, out_valid, bin_out, ovf, err
    );

    modport slave (
        input  in_valid, bcd_h, bcd_t, bcd_o, out_ready,
        output in_ready, out_valid, bin_out, ovf, err
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential 3-digit BCD to 8-bit binary converter (reverse double dabble, one step per clock).
// Latency: accept + 10 steps for valid digits, 1 edge for bad digits. The result is held until out_ready.
module bcd_to_bin_seq #(
    parameter bit SAT_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    bcd_to_bin_seq_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [11:0] bcd_q, bcd_d;
    logic [9:0]  res_q, res_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  bin_q, bin_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;

    logic        digit_bad;
    logic [21:0] shifted;
    logic [11:0] bcd_adj;
    logic        res_big;

    always_comb begin
        digit_bad = (bus.bcd_h > 4'd9) || (bus.bcd_t > 4'd9) || (bus.bcd_o > 4'd9);
        shifted   = {bcd_q, res_q} >> 1;
        res_big   = (shifted[9:0] > 10'd255);
        // Undo the x2 weighting of each decimal nibble. Nibbles do not carry into each other.
        bcd_adj   = shifted[21:10];
        for (int i = 0; i < 3; i++) begin
            if (shifted[10 + i*4 +: 4] >= 4'd8)
                bcd_adj[i*4 +: 4] = shifted[10 + i*4 +: 4] - 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (digit_bad) begin
                        err_d   = 1'b1;
                        bin_d   = 8'h00;
                        ovf_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        bcd_d   = {bus.bcd_h, bus.bcd_t, bus.bcd_o};
                        res_d   = 10'd0;
                        cnt_d   = 4'd0;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                bcd_d = bcd_adj;
                res_d = shifted[9:0];
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    err_d   = 1'b0;
                    ovf_d   = res_big;
                    bin_d   = (res_big && SAT_EN) ? 8'hFF : shifted[7:0];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bcd_q   <= 12'd0;
            res_q   <= 10'd0;
            cnt_q   <= 4'd0;
            bin_q   <= 8'd0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.bin_out   = bin_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;
endmodule
